// File: rtl/signed_mp_pkg.sv
// signed_mp_pkg
// Shared definitions for the multi-precision signed add/subtract sequencer:
//   - BYTE_W        : width of the shared adder slice (8)
//   - state_t       : sequencer states IDLE / RUN / DONE
//   - cnt_width()   : byte-counter width for a given NBYTES
//   - sat_max/min() : saturation limits for a W-bit signed result (W <= 128).
//                     They are used by the top when SIGNED_MP_SAT_EN is defined.
package signed_mp_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // At least one bit, so that NBYTES=1 would still give a legal vector.
  function automatic int cnt_width(input int nbytes);
    return (nbytes < 2) ? 1 : $clog2(nbytes);
  endfunction

  // Largest positive W-bit two's-complement value (0x7F..FF), zero-extended to 128 bits.
  function automatic logic [127:0] sat_max(input int w);
    return (128'd1 << (w - 1)) - 128'd1;
  endfunction

  // Most negative W-bit two's-complement value (0x80..00), zero-extended to 128 bits.
  function automatic logic [127:0] sat_min(input int w);
    return 128'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/byte_fadd_slice.sv
// byte_fadd_slice
// Purely combinational 8-bit full-adder slice, the only adder in the sequencer.
// Ports:
//   i_a, i_b  : 8-bit operand bytes (i_b already inverted for subtraction)
//   i_cin     : carry in
//   o_sum     : 8-bit sum byte
//   o_cout    : carry out of bit 7
//   o_overflow: signed overflow, meaningful only for the most-significant byte
module byte_fadd_slice
  import signed_mp_pkg::*;
(
  input  logic [BYTE_W-1:0] i_a,
  input  logic [BYTE_W-1:0] i_b,
  input  logic              i_cin,
  output logic [BYTE_W-1:0] o_sum,
  output logic              o_cout,
  output logic              o_overflow
);

  logic [BYTE_W:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{BYTE_W{1'b0}}, i_cin};
  assign o_sum  = w_full[BYTE_W-1:0];
  assign o_cout = w_full[BYTE_W];

  // Overflow: both operand signs agree and the result sign differs from them.
  assign o_overflow = (i_a[BYTE_W-1] & i_b[BYTE_W-1] & ~o_sum[BYTE_W-1]) |
                      (~i_a[BYTE_W-1] & ~i_b[BYTE_W-1] & o_sum[BYTE_W-1]);

endmodule

// File: rtl/signed_mp_add_seq.sv
// signed_mp_add_seq
// Multi-precision signed add/subtract sequencer. One operation is processed
// one byte per cycle, LSB first, through a single byte_fadd_slice, with carry
// chained between bytes in a register.
// Optional feature macro: SIGNED_MP_SAT_EN (saturate sum on signed overflow;
// overflow/cout still report the unsaturated condition).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (a, b, cin, op_sub)
//   out_valid/ out_ready: result handshake (sum, cout, overflow)
//   dbg_state           : current sequencer state (state_t encoding)
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. in_ready is high only in IDLE (and never during reset); out_valid is
// high only in DONE. A producer may not assume ready before it sees it, and
// sum/cout/overflow are meaningful only while out_valid is high.
module signed_mp_add_seq
  import signed_mp_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  input  logic                  cin,
  input  logic                  op_sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   sum,
  output logic                  cout,
  output logic                  overflow,
  output logic [1:0]            dbg_state
);

  localparam int W     = BYTE_W * NBYTES;
  localparam int CNT_W = cnt_width(NBYTES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES - 1);

  localparam logic [1:0] ST_IDLE = S_IDLE;
  localparam logic [1:0] ST_RUN  = S_RUN;
  localparam logic [1:0] ST_DONE = S_DONE;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_a;      // operand A, shifted right one byte per RUN cycle
  logic [W-1:0]     r_b;      // operand B (already inverted for subtract)
  logic             r_carry;  // carry into the current byte
  logic [W-1:0]     r_acc;    // partial result, bytes enter at the top
  logic [W-1:0]     r_sum;    // presented result, only updated on entry to DONE
  logic             r_cout;
  logic             r_ovf;

  logic [BYTE_W-1:0] w_slice_sum;
  logic              w_slice_cout;
  logic              w_slice_ovf;
  logic [W-1:0]      w_full;
  logic [W-1:0]      w_result;

  byte_fadd_slice u_slice (
    .i_a        (r_a[BYTE_W-1:0]),
    .i_b        (r_b[BYTE_W-1:0]),
    .i_cin      (r_carry),
    .o_sum      (w_slice_sum),
    .o_cout     (w_slice_cout),
    .o_overflow (w_slice_ovf)
  );

  // Complete result as it will look after the final byte is shifted in.
  assign w_full = {w_slice_sum, r_acc[W-1:BYTE_W]};

`ifdef SIGNED_MP_SAT_EN
  localparam logic [W-1:0] SAT_POS = W'(sat_max(W));
  localparam logic [W-1:0] SAT_NEG = W'(sat_min(W));
  // On the final byte r_a[7] is the sign of A, which picks the saturation side.
  assign w_result = w_slice_ovf ? (r_a[BYTE_W-1] ? SAT_NEG : SAT_POS) : w_full;
`else
  assign w_result = w_full;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= op_sub ? ~b : b;
            // Subtraction is A + ~B + 1, so cin is not used then.
            r_carry <= op_sub ? 1'b1 : cin;
            r_cnt   <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_a     <= r_a >> BYTE_W;
          r_b     <= r_b >> BYTE_W;
          r_acc   <= w_full;
          r_carry <= w_slice_cout;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_CNT) begin
            r_sum   <= w_result;
            r_cout  <= w_slice_cout;
            r_ovf   <= w_slice_ovf;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // rst_n gates in_ready so that it is low for the whole reset interval.
  assign in_ready  = rst_n && (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign overflow  = r_ovf;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_signed_mp_add_seq.sv
module tb_signed_mp_add_seq;

  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;
  localparam int LAT    = NBYTES;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cin;
  logic          op_sub;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum;
  logic          cout;
  logic          overflow;
  logic [1:0]    dbg_state;

  // Expected entries: {cout, overflow, sum}
  logic [W+1:0] exp_q[$];

  int total;
  int bad;

  signed_mp_add_seq #(.NBYTES(NBYTES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c, input logic s);
    logic [W-1:0] yy;
    logic [W:0]   t;
    logic         ov;
    logic [W-1:0] r;
    yy = s ? ~y : y;
    t  = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, (s ? 1'b1 : c)};
    ov = (x[W-1] == yy[W-1]) && (t[W-1] != x[W-1]);
    r  = t[W-1:0];
`ifdef SIGNED_MP_SAT_EN
    if (ov) r = x[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    return {t[W], ov, r};
  endfunction

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; op_sub = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  // Present one operand at a negedge, transfer on the next rising edge,
  // record the expected result.
  task automatic drive_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic c, input logic s);
    @(negedge clk);
    a = x; b = y; cin = c; op_sub = s;
    in_valid = 1'b1;
    chk("in_ready_before_accept", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    exp_q.push_back(model(x, y, c, s));
  endtask

  // Wait (bounded) for out_valid; returns cycles since accept, 0 on timeout.
  task automatic wait_valid(output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    chk("latency", 64'(lat), 64'(LAT));
  endtask

  task automatic check_result(input string tag);
    logic [W+1:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_nonempty"}, 64'd0, 64'd1);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_sum"}, 64'(sum), 64'(e[W-1:0]));
    chk({tag, "_ovf"}, 64'(overflow), 64'(e[W]));
    chk({tag, "_cout"}, 64'(cout), 64'(e[W+1]));
  endtask

  // Full transaction: drive, wait, compare, consume the result.
  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic c, input logic s);
    int lat;
    drive_op(x, y, c, s);
    wait_valid(lat);
    if (lat == 0) return;
    chk({tag, "_in_ready_done"}, 64'(in_ready), 64'd0);
    check_result(tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_out_valid_after"}, 64'(out_valid), 64'd0);
    chk({tag, "_in_ready_after"}, 64'(in_ready), 64'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    logic [W-1:0] held_sum;
    logic         held_cout;
    logic         held_ovf;
    total = 0;
    bad   = 0;

    do_reset();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Carry ripple across a byte boundary.
    run_op("carry_chain", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    // Positive signed overflow.
    run_op("pos_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    // Subtract with negative overflow; cin ignored.
    run_op("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    run_op("sub_cin_ign", 32'h0000_0010, 32'h0000_0003, 1'b1, 1'b1);
    // Carry out without overflow, cin used.
    run_op("cout_no_ovf", 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0);
    // Subtraction with borrow (cout=0).
    run_op("sub_borrow", 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b1);

    // Constants taken from the plan, independent of the model.
    drive_op(32'h0000_0002, 32'h0000_0003, 1'b0, 1'b0);
    wait_valid(lat);
    chk("plan_2p3_sum", 64'(sum), 64'h5);
    check_result("plan_2p3");
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // out_ready held high through RUN must not end the operation early.
    @(negedge clk);
    out_ready = 1'b1;
    drive_op(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b0);
    wait_valid(lat);
    check_result("early_ready");
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("early_ready_out_valid_after", 64'(out_valid), 64'd0);

    // Random operations.
    for (int i = 0; i < 8; i++) begin
      run_op("rand", W'($urandom()), W'($urandom()), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
    end

    // Backpressure: hold DONE for 5 cycles while a new request is offered.
    drive_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    wait_valid(lat);
    held_sum  = sum;
    held_cout = cout;
    held_ovf  = overflow;
    check_result("bp");
    @(negedge clk);
    a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_sum_stable", 64'(sum), 64'(held_sum));
      chk("bp_cout_stable", 64'(cout), 64'(held_cout));
      chk("bp_ovf_stable", 64'(overflow), 64'(held_ovf));
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("bp_release_out_valid", 64'(out_valid), 64'd0);
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    chk("bp_sum_held_idle", 64'(sum), 64'(held_sum));
    // The offered request must never have been taken.
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      chk("bp_no_spurious", 64'(out_valid), 64'd0);
    end

    // Reset in the middle of RUN.
    drive_op(32'h7654_3210, 32'h0123_4567, 1'b0, 1'b0);
    void'(exp_q.pop_back());
    repeat (2) @(posedge clk);
    #1;
    chk("midrun_state", 64'(dbg_state), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_out_valid", 64'(out_valid), 64'd0);
    chk("midrun_rst_sum", 64'(sum), 64'd0);
    chk("midrun_rst_cout", 64'(cout), 64'd0);
    chk("midrun_rst_ovf", 64'(overflow), 64'd0);
    chk("midrun_rst_in_ready", 64'(in_ready), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      chk("midrun_no_partial", 64'(out_valid), 64'd0);
    end
    run_op("after_rst", 32'h0000_0002, 32'h0000_0003, 1'b0, 1'b0);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
